// File: rtl/ring_ctrl.sv
// Chime/alarm sequencer for the clock's buzzer stage. It produces the ring select code
// and the clk_slow/clk_fast gating waves, all registered one clk behind the FSM state.
//
// state | meaning
// IDLE  | silent, dividers held at zero
// CHIME | hourly slow-pattern chime, CHIME_SECS further ticks
// ALARM | alarm fast pattern, ALARM_SECS further ticks
module ring_ctrl #(
   parameter int SLOW_DIV   = 500,
   parameter int FAST_DIV   = 125,
   parameter int CHIME_SECS = 5,
   parameter int ALARM_SECS = 30
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       sec_tick_i,
   input  logic [7:0] hour_i,
   input  logic [7:0] min_i,
   input  logic [7:0] sec_i,
   input  logic [7:0] alarm_hour_i,
   input  logic [7:0] alarm_min_i,
   input  logic       alarm_en_i,
   input  logic       stop_i,
   output logic [1:0] ring_o,
   output logic       clk_slow_o,
   output logic       clk_fast_o,
   output logic       busy_o
);

   localparam int SW = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;
   localparam int FW = (FAST_DIV > 1) ? $clog2(FAST_DIV) : 1;
   localparam int DMAX = (ALARM_SECS > CHIME_SECS) ? ALARM_SECS : CHIME_SECS;
   localparam int DW = $clog2(DMAX + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      CHIME = 2'b01,
      ALARM = 2'b10
   } state_t;

   state_t          state_q, state_d;
   logic [DW-1:0]   dur_q, dur_d;
   logic [SW-1:0]   slow_cnt_q, slow_cnt_d;
   logic [FW-1:0]   fast_cnt_q, fast_cnt_d;
   logic            clk_slow_q, clk_slow_d;
   logic            clk_fast_q, clk_fast_d;
   logic [1:0]      ring_q, ring_d;
   logic            busy_q, busy_d;

   logic alarm_hit;
   logic chime_hit;
   logic div_run;
   logic slow_wrap;
   logic fast_wrap;

   assign alarm_hit = sec_tick_i & alarm_en_i & (hour_i == alarm_hour_i)
                      & (min_i == alarm_min_i) & (sec_i == 8'h00);
   assign chime_hit = sec_tick_i & (min_i == 8'h00) & (sec_i == 8'h00);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         dur_q      <= '0;
         slow_cnt_q <= '0;
         fast_cnt_q <= '0;
         clk_slow_q <= 1'b0;
         clk_fast_q <= 1'b0;
         ring_q     <= 2'b00;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         dur_q      <= dur_d;
         slow_cnt_q <= slow_cnt_d;
         fast_cnt_q <= fast_cnt_d;
         clk_slow_q <= clk_slow_d;
         clk_fast_q <= clk_fast_d;
         ring_q     <= ring_d;
         busy_q     <= busy_d;
      end
   end

   // stop outranks every trigger, including an alarm preempting a chime
   always_comb begin
      state_d = state_q;
      dur_d   = dur_q;
      case (state_q)
         IDLE: begin
            if (!stop_i) begin
               if (alarm_hit) begin
                  state_d = ALARM;
                  dur_d   = DW'(ALARM_SECS);
               end else if (chime_hit) begin
                  state_d = CHIME;
                  dur_d   = DW'(CHIME_SECS);
               end
            end
         end
         CHIME: begin
            if (stop_i) begin
               state_d = IDLE;
               dur_d   = '0;
            end else if (alarm_hit) begin
               state_d = ALARM;
               dur_d   = DW'(ALARM_SECS);
            end else if (sec_tick_i) begin
               dur_d = dur_q - DW'(1);
               if (dur_q <= DW'(1)) begin
                  state_d = IDLE;
                  dur_d   = '0;
               end
            end
         end
         ALARM: begin
            if (stop_i) begin
               state_d = IDLE;
               dur_d   = '0;
            end else if (sec_tick_i) begin
               dur_d = dur_q - DW'(1);
               if (dur_q <= DW'(1)) begin
                  state_d = IDLE;
                  dur_d   = '0;
               end
            end
         end
         default: begin
            state_d = IDLE;
            dur_d   = '0;
         end
      endcase
   end

   // Dividers start counting once ring is visible so the first toggle lands DIV clks later
   assign div_run   = (state_q != IDLE) & busy_q;
   assign slow_wrap = (slow_cnt_q == SW'(SLOW_DIV - 1));
   assign fast_wrap = (fast_cnt_q == FW'(FAST_DIV - 1));

   always_comb begin
      ring_d     = 2'b00;
      busy_d     = 1'b0;
      slow_cnt_d = '0;
      fast_cnt_d = '0;
      clk_slow_d = 1'b0;
      clk_fast_d = 1'b0;
      case (state_q)
         CHIME:   ring_d = 2'b01;
         ALARM:   ring_d = 2'b10;
         default: ring_d = 2'b00;
      endcase
      if (state_q != IDLE) begin
         busy_d     = 1'b1;
         clk_slow_d = clk_slow_q;
         clk_fast_d = clk_fast_q;
         if (div_run) begin
            slow_cnt_d = slow_wrap ? '0 : slow_cnt_q + SW'(1);
            fast_cnt_d = fast_wrap ? '0 : fast_cnt_q + FW'(1);
            if (slow_wrap) clk_slow_d = ~clk_slow_q;
            if (fast_wrap) clk_fast_d = ~clk_fast_q;
         end
      end
   end

   assign ring_o     = ring_q;
   assign busy_o     = busy_q;
   assign clk_slow_o = clk_slow_q;
   assign clk_fast_o = clk_fast_q;

endmodule

// File: doc/ring_ctrl.md
Name: ring_ctrl

Overview:
Alarm/chime sequencer for the digital clock. It sits directly upstream of the buzzer driver stage and produces that stage's ring[1:0] select code plus its two gating square waves, clk_slow and clk_fast. It watches the BCD time-of-day from the clock counter and the user alarm setting. It issues a short slow-pattern chime on every hour and a longer fast-pattern alarm on an alarm match. A stop key cancels either pattern early.

Parameters:
SLOW_DIV, 500, clk cycles per half-period of clk_slow (toggle interval)
FAST_DIV, 125, clk cycles per half-period of clk_fast
CHIME_SECS, 5, chime duration in sec_tick pulses
ALARM_SECS, 30, alarm duration in sec_tick pulses

Ports:
clk  in  1  system clock, single clock domain
rst  in  1  synchronous reset, active-high
sec_tick  in  1  one-cycle pulse, once per second, from the clock counter
hour  in  8  current hour, BCD 00-23
min  in  8  current minute, BCD 00-59
sec  in  8  current second, BCD 00-59
alarm_hour  in  8  alarm hour, BCD
alarm_min  in  8  alarm minute, BCD
alarm_en  in  1  alarm armed
stop  in  1  one-cycle stop pulse (already debounced)
ring  out  2  00 silent, 01 chime (slow), 10 alarm (fast); 11 never driven
clk_slow  out  1  slow gating square wave
clk_fast  out  1  fast gating square wave
busy  out  1  high while CHIME or ALARM is active

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; ring=00, clk_slow=0, clk_fast=0, busy=0.
  - Divider counters and duration counter are cleared.
  - Reset mid-pattern aborts the pattern immediately, with no residual output.
- Inputs are sampled only in a cycle where sec_tick=1; time inputs are ignored otherwise. BCD validity is not checked.
- Trigger conditions, evaluated only when sec_tick=1:
  - alarm_hit = alarm_en & hour==alarm_hour & min==alarm_min & sec==8'h00
  - chime_hit = min==8'h00 & sec==8'h00
- State machine (states IDLE, CHIME, ALARM):
  - IDLE -> ALARM on alarm_hit. Alarm has priority when both hits occur together.
  - IDLE -> CHIME on chime_hit with no alarm_hit.
  - CHIME -> ALARM on alarm_hit (alarm preempts chime; duration counter reloads).
  - CHIME -> IDLE when its duration expires or on stop.
  - ALARM -> IDLE when its duration expires or on stop. chime_hit is ignored in ALARM.
  - stop in IDLE: no effect.
  - stop in the same cycle as a trigger from IDLE: stop wins, state stays IDLE.
  - stop in the same cycle as a preempting alarm_hit in CHIME: stop wins, -> IDLE.
- Duration:
  - On entry, the counter loads CHIME_SECS or ALARM_SECS.
  - The entry tick itself is not counted.
  - Each subsequent sec_tick decrements the counter; the tick that reaches 0 returns the FSM to IDLE.
  - Net effect: the pattern lasts exactly N further sec_ticks.
- Outputs are registered and change 1 clk after the triggering or ending edge:
  - ring = 01 in CHIME, 10 in ALARM, 00 in IDLE.
  - busy = (state != IDLE).
- Dividers:
  - Held at count 0 with outputs at 0 while IDLE.
  - On entry to an active state, both counters start from 0.
  - clk_slow toggles every SLOW_DIV cycles; clk_fast toggles every FAST_DIV cycles.
  - First toggle occurs SLOW_DIV / FAST_DIV cycles after ring becomes non-zero.
  - Both run in CHIME and in ALARM; the downstream stage selects between them via ring.
  - On return to IDLE, both outputs go to 0 on the same edge that ring goes to 00.
- Counter widths are sized by $clog2 of the respective parameter. No wrap beyond the parameter value.

Test Plan:
Use SLOW_DIV=4, FAST_DIV=2, CHIME_SECS=3, ALARM_SECS=5, with a sec_tick every 20 clks.
1. Hourly chime: hour=8'h07, min=8'h00, sec=8'h00 on a tick -> ring=01 and busy=1 one clk later; clk_slow toggles every 4 clks; ring returns to 00 one clk after the 3rd following tick.
2. Alarm: alarm_en=1, alarm 07:30, time 07:30:00 on a tick -> ring=10; clk_fast period is 4 clks; pattern ends one clk after the 5th following tick. With alarm_en=0 and the same time -> ring stays 00.
3. Priority and preempt:
   - Alarm 08:00 with time 08:00:00 -> ring=10, not 01.
   - CHIME active when an alarm match arrives -> ring 01->10, and the duration reloads to 5.
4. Stop:
   - stop pulse 7 clks into ALARM -> ring=00, busy=0, clk_fast=0 next clk.
   - stop in the same cycle as the trigger -> ring stays 00.
   - stop in IDLE -> no change.
5. Reset mid-ALARM -> ring=00, clk_slow=clk_fast=0, busy=0 after the edge. A later matching tick restarts the full 5-tick pattern.
6. Non-trigger ticks (sec=8'h01, min=8'h00; or min=8'h15, sec=8'h00 with no alarm) and time matching while sec_tick=0 -> ring remains 00 throughout.
